// File: rtl/cu_pipe_ckpt.sv
// cu_pipe_ckpt: control-word pipeline with freeze, per-stage dirty
// tracking, dirty-only checkpoint readout and indexed restore writes.
module cu_pipe_ckpt #(
    parameter int STAGES = 3,
    parameter int W = 32,
    parameter logic [W-1:0] RESET_WORD = '0,
    parameter logic [W-1:0] BUBBLE_WORD = '0,
    localparam int IW = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  stand_by,
    input  logic [W-1:0]          word_in,
    output logic [STAGES*W-1:0]   ctrl_out,
    output logic [STAGES-1:0]     dirty,
    input  logic                  bk_req,
    output logic                  bk_valid,
    output logic [IW-1:0]         bk_idx,
    output logic [W-1:0]          bk_data,
    input  logic                  bk_ack,
    output logic                  bk_done,
    input  logic                  rs_valid,
    input  logic [IW-1:0]         rs_idx,
    input  logic [W-1:0]          rs_data,
    output logic                  rs_ready,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        OFFER,
        DONE
    } state_t;

    localparam logic [IW-1:0] LAST = IW'(STAGES - 1);

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [W-1:0]      stage_q [STAGES];
    logic [W-1:0]      stage_d [STAGES];
    logic [STAGES-1:0] dirty_q, dirty_d;

    logic is_idle;
    logic is_last;
    logic adv;
    logic rs_fire;
    logic rs_hit;

    assign is_idle  = (state_q == IDLE);
    assign is_last  = (idx_q == LAST);
    assign rs_ready = is_idle & ~bk_req;
    assign rs_fire  = rs_valid & rs_ready;
    // Out-of-range restore targets are accepted but write nothing.
    assign rs_hit   = rs_fire & (int'(rs_idx) < STAGES);
    assign adv      = ~stand_by & is_idle & ~rs_fire;

    assign busy     = ~is_idle;
    assign bk_valid = (state_q == OFFER);
    assign bk_idx   = idx_q;
    assign bk_data  = stage_q[idx_q];
    assign bk_done  = (state_q == DONE);
    assign dirty    = dirty_q;

    // Stage registers and dirty flags: shift, restore write, backup clear.
    always_comb begin
        stage_d = stage_q;
        dirty_d = dirty_q;
        if (adv) begin
            stage_d[0] = word_in;
            for (int k = 1; k < STAGES; k++) begin
                stage_d[k] = stage_q[k-1];
            end
            dirty_d = '1;
        end
        if (rs_hit) begin
            stage_d[rs_idx] = rs_data;
            dirty_d[rs_idx] = 1'b0;
        end
        if ((state_q == OFFER) && bk_ack) begin
            dirty_d[idx_q] = 1'b0;
        end
    end

    // Checkpoint walker: visit each stage once, offer only dirty ones.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (bk_req) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (dirty_q[idx_q]) begin
                    state_d = OFFER;
                end else if (is_last) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            OFFER: begin
                if (bk_ack) begin
                    if (is_last) begin
                        state_d = DONE;
                    end else begin
                        state_d = SCAN;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Live stage view only when idle and not frozen, bubbles otherwise.
    always_comb begin
        ctrl_out = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (is_idle && !stand_by) begin
                ctrl_out[k*W +: W] = stage_q[k];
            end else begin
                ctrl_out[k*W +: W] = BUBBLE_WORD;
            end
        end
    end

    // State update; reset overrides everything, including a checkpoint.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dirty_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= RESET_WORD;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dirty_q <= dirty_d;
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

endmodule

// File: tb/tb_cu_pipe_ckpt.sv
// tb_cu_pipe_ckpt: directed vector table plus hand sequences for
// reset-during-offer and backup/restore collision.
module tb_cu_pipe_ckpt;

    localparam int STAGES = 3;
    localparam int W = 8;
    localparam int IW = 2;

    logic                Clk = 1'b0;
    logic                Rst;
    logic                stand_by;
    logic [W-1:0]        word_in;
    logic [STAGES*W-1:0] ctrl_out;
    logic [STAGES-1:0]   dirty;
    logic                bk_req;
    logic                bk_valid;
    logic [IW-1:0]       bk_idx;
    logic [W-1:0]        bk_data;
    logic                bk_ack;
    logic                bk_done;
    logic                rs_valid;
    logic [IW-1:0]       rs_idx;
    logic [W-1:0]        rs_data;
    logic                rs_ready;
    logic                busy;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    cu_pipe_ckpt #(
        .STAGES(STAGES),
        .W(W)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .stand_by(stand_by),
        .word_in(word_in),
        .ctrl_out(ctrl_out),
        .dirty(dirty),
        .bk_req(bk_req),
        .bk_valid(bk_valid),
        .bk_idx(bk_idx),
        .bk_data(bk_data),
        .bk_ack(bk_ack),
        .bk_done(bk_done),
        .rs_valid(rs_valid),
        .rs_idx(rs_idx),
        .rs_data(rs_data),
        .rs_ready(rs_ready),
        .busy(busy)
    );

    typedef struct packed {
        logic        chk;
        logic        rst;
        logic        sb;
        logic [7:0]  win;
        logic        bkr;
        logic        bka;
        logic        rsv;
        logic [1:0]  rsi;
        logic [7:0]  rsd;
        logic [23:0] e_ctrl;
        logic [2:0]  e_dirty;
        logic        e_bkv;
        logic [1:0]  e_bki;
        logic [7:0]  e_bkd;
        logic        e_done;
        logic        e_rsr;
        logic        e_busy;
    } vec_t;

    vec_t tv [20];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic sb,
                         input logic [7:0] win, input logic bkr,
                         input logic bka, input logic rsv,
                         input logic [1:0] rsi, input logic [7:0] rsd);
        Rst      = rst;
        stand_by = sb;
        word_in  = win;
        bk_req   = bkr;
        bk_ack   = bka;
        rs_valid = rsv;
        rs_idx   = rsi;
        rs_data  = rsd;
    endtask

    initial begin
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);

        //          chk  rst  sb   win    bkr  bka  rsv  rsi   rsd
        //          ctrl        dirty   bkv  bki   bkd    done rsr  busy
        tv[0]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00,
                   24'h000000, 3'b000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00,
                   24'h000000, 3'b000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0};
        tv[2]  = '{1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00,
                   24'h000011, 3'b111, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0};
        tv[3]  = '{1'b1, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00,
                   24'h001122, 3'b111, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0};
        tv[4]  = '{1'b1, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00,
                   24'h000000, 3'b111, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0};
        tv[5]  = '{1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00,
                   24'h000000, 3'b111, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0};
        tv[6]  = '{1'b1, 1'b0, 1'b0, 8'h66, 1'b0, 1'b0, 1'b1, 2'd1, 8'hA5,
                   24'h112233, 3'b111, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0};
        tv[7]  = '{1'b1, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 2'd3, 8'hFF,
                   24'h11A533, 3'b101, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0};
        tv[8]  = '{1'b1, 1'b0, 1'b1, 8'h88, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00,
                   24'h000000, 3'b101, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00,
                   24'h000000, 3'b101, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1};
        tv[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00,
                   24'h000000, 3'b101, 1'b1, 2'd0, 8'h33, 1'b0, 1'b0, 1'b1};
        tv[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00,
                   24'h000000, 3'b101, 1'b1, 2'd0, 8'h33, 1'b0, 1'b0, 1'b1};
        tv[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00,
                   24'h000000, 3'b101, 1'b1, 2'd0, 8'h33, 1'b0, 1'b0, 1'b1};
        tv[13] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00,
                   24'h000000, 3'b100, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1};
        tv[14] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00,
                   24'h000000, 3'b100, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1};
        tv[15] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00,
                   24'h000000, 3'b100, 1'b1, 2'd2, 8'h11, 1'b0, 1'b0, 1'b1};
        tv[16] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00,
                   24'h000000, 3'b100, 1'b1, 2'd2, 8'h11, 1'b0, 1'b0, 1'b1};
        tv[17] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00,
                   24'h000000, 3'b100, 1'b1, 2'd2, 8'h11, 1'b0, 1'b0, 1'b1};
        tv[18] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00,
                   24'h000000, 3'b000, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1};
        tv[19] = '{1'b1, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00,
                   24'h11A533, 3'b000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            drive(tv[i].rst, tv[i].sb, tv[i].win, tv[i].bkr,
                  tv[i].bka, tv[i].rsv, tv[i].rsi, tv[i].rsd);
            #1;
            if (tv[i].chk) begin
                chk($sformatf("v%0d ctrl_out", i), 32'(ctrl_out), 32'(tv[i].e_ctrl));
                chk($sformatf("v%0d dirty", i), 32'(dirty), 32'(tv[i].e_dirty));
                chk($sformatf("v%0d bk_valid", i), 32'(bk_valid), 32'(tv[i].e_bkv));
                chk($sformatf("v%0d bk_done", i), 32'(bk_done), 32'(tv[i].e_done));
                chk($sformatf("v%0d rs_ready", i), 32'(rs_ready), 32'(tv[i].e_rsr));
                chk($sformatf("v%0d busy", i), 32'(busy), 32'(tv[i].e_busy));
                if (tv[i].e_bkv) begin
                    chk($sformatf("v%0d bk_idx", i), 32'(bk_idx), 32'(tv[i].e_bki));
                    chk($sformatf("v%0d bk_data", i), 32'(bk_data), 32'(tv[i].e_bkd));
                end
            end
        end

        // Reset while a word is on offer: stages now 0xA5,0x33,0x99.
        @(negedge Clk);
        drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        @(negedge Clk);
        drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        @(negedge Clk);
        #1;
        chk("rstoffer bk_valid before", 32'(bk_valid), 32'd1);
        chk("rstoffer bk_data before", 32'(bk_data), 32'h99);
        drive(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        @(negedge Clk);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        #1;
        chk("rstoffer bk_valid", 32'(bk_valid), 32'd0);
        chk("rstoffer busy", 32'(busy), 32'd0);
        chk("rstoffer bk_done", 32'(bk_done), 32'd0);
        chk("rstoffer ctrl_out", 32'(ctrl_out), 32'h0);
        chk("rstoffer dirty", 32'(dirty), 32'd0);
        chk("rstoffer rs_ready", 32'(rs_ready), 32'd1);
        stand_by = 1'b1;
        @(negedge Clk);
        #1;
        chk("rstoffer no late done", 32'(bk_done), 32'd0);
        chk("rstoffer still idle", 32'(busy), 32'd0);

        // Backup request collides with a restore: backup wins.
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd1, 8'h5A);
        #1;
        chk("collide pre rs_ready", 32'(rs_ready), 32'd1);
        @(negedge Clk);
        drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 2'd1, 8'hC3);
        #1;
        chk("collide rs_ready", 32'(rs_ready), 32'd0);
        @(negedge Clk);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        #1;
        chk("collide busy", 32'(busy), 32'd1);
        chk("collide scan bk_valid", 32'(bk_valid), 32'd0);
        @(negedge Clk);
        #1;
        chk("collide scan1 done", 32'(bk_done), 32'd0);
        @(negedge Clk);
        #1;
        chk("collide scan2 done", 32'(bk_done), 32'd0);
        @(negedge Clk);
        #1;
        chk("collide done pulse", 32'(bk_done), 32'd1);
        @(negedge Clk);
        #1;
        chk("collide back idle", 32'(busy), 32'd0);
        chk("collide done cleared", 32'(bk_done), 32'd0);
        chk("collide stage1 kept", 32'(ctrl_out), 32'h005A00);
        chk("collide dirty", 32'(dirty), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cu_pipe_ckpt.md
CU_PIPE_CKPT -- requirements
Module: cu_pipe_ckpt

Interface
REQ-001 The block SHALL have parameter STAGES, default 3: number of control-word pipeline stages (legal range 1..16).
REQ-002 The block SHALL have parameter W, default 32: width of each stage register.
REQ-003 The block SHALL have parameter RESET_WORD, default all-zero: value every stage register loads on reset.
REQ-004 The block SHALL have parameter BUBBLE_WORD, default all-zero: value presented per stage while the pipeline is frozen.
REQ-005 The block SHALL use IW = max(1, clog2(STAGES)) as the stage-index width.
REQ-006 Clk  in  1  single clock; all state changes on its rising edge.
REQ-007 Rst  in  1  reset, synchronous, active-high.
REQ-008 stand_by  in  1  freeze request: hold all stages, present bubbles.
REQ-009 word_in  in  W  next control word entering stage 0.
REQ-010 ctrl_out  out  STAGES*W  stage k output on bits [k*W +: W].
REQ-011 dirty  out  STAGES  per-stage dirty flag, bit k for stage k.
REQ-012 bk_req  in  1  start-checkpoint pulse.
REQ-013 bk_valid  out  1  backup word offered.
REQ-014 bk_idx  out  IW  stage index of the offered word.
REQ-015 bk_data  out  W  offered stage contents.
REQ-016 bk_ack  in  1  consumer accepts the offered word.
REQ-017 bk_done  out  1  one-cycle pulse: checkpoint complete.
REQ-018 rs_valid  in  1  restore write request.
REQ-019 rs_idx  in  IW  restore target stage.
REQ-020 rs_data  in  W  restore value.
REQ-021 rs_ready  out  1  restore write accepted this cycle.
REQ-022 busy  out  1  FSM not in IDLE.

Function
REQ-023 FSM states SHALL be IDLE, SCAN, OFFER, DONE; busy = (state != IDLE).
REQ-024 Pipeline advance adv = ~stand_by & (state == IDLE) & ~(rs_valid & rs_ready); on adv, stage0 <= word_in and stage k <= stage k-1, with dirty[k] set for every stage.
REQ-025 When not advancing, stage contents and dirty flags SHALL be held except as changed by REQ-030/REQ-032.
REQ-026 ctrl_out SHALL present the stage registers when (state == IDLE) & ~stand_by, otherwise BUBBLE_WORD in every slot; this selection is combinational.
REQ-027 IDLE and bk_req=1 SHALL move to SCAN with scan index 0; bk_req outside IDLE is ignored.
REQ-028 SCAN, index i: if dirty[i], move to OFFER; if clean and i = STAGES-1, move to DONE; if clean otherwise, i <= i+1. A clean stage costs exactly one cycle.
REQ-029 OFFER: bk_valid=1, bk_idx=i, bk_data=stage i; values SHALL remain stable until bk_ack.
REQ-030 OFFER with bk_ack=1: clear dirty[i]; go to DONE if i = STAGES-1, otherwise go to SCAN with i+1. bk_ack outside OFFER is ignored.
REQ-031 DONE SHALL assert bk_done for exactly one cycle, then return to IDLE.
REQ-032 rs_ready = (state == IDLE) & ~bk_req; rs_valid & rs_ready with rs_idx < STAGES writes stage[rs_idx] <= rs_data and clears dirty[rs_idx]; the pipeline does not advance that cycle.
REQ-033 A restore with rs_idx >= STAGES SHALL be acknowledged by rs_ready and have no effect on state; the pipeline still does not advance.
REQ-034 Simultaneous bk_req and rs_valid in IDLE: backup wins, rs_ready=0, no write.
REQ-035 stand_by during SCAN/OFFER/DONE SHALL not affect checkpoint progress.

Reset
REQ-036 Rst=1 at a clock edge SHALL set all stages to RESET_WORD, dirty to 0, state to IDLE, and scan index to 0, overriding every other input, including mid-checkpoint.
REQ-037 After reset: bk_valid=0, bk_done=0, busy=0, rs_ready = ~bk_req, and ctrl_out = RESET_WORD per stage unless stand_by=1.

Verification (STAGES=3, W=8)
REQ-038 Reset, then word_in 0x11, 0x22, 0x33 on three edges -> ctrl_out = {0x11, 0x22, 0x33} (stage2..stage0); dirty = 3'b111.
REQ-039 stand_by=1 for 2 cycles while word_in changes -> ctrl_out = 0x00 in all slots, stages unchanged; after release, the original words reappear.
REQ-040 dirty=3'b101, bk_req pulse, bk_ack delayed 2 cycles per offer -> offers idx0 then idx2 only, bk_data stable while waiting; bk_done pulses once; dirty = 0.
REQ-041 Restore idx1=0xA5, then idx3=0xFF -> stage1=0xA5 with dirty[1]=0; idx3 has no effect; no pipeline advance in either cycle.
REQ-042 Rst asserted while bk_valid=1 -> next cycle bk_valid=0, busy=0, stages=RESET_WORD, and no bk_done pulse.
REQ-043 bk_req and rs_valid asserted in the same cycle -> rs_ready=0, the target stage is unchanged, and the checkpoint starts.
